// File: rtl/regfile_read_scheduler_if.sv
// Request/response bundle between operand-fetch clients and the register-file
// read scheduler; master is the client side, slave is the scheduler.
interface regfile_read_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_addr;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [31:0]       resp_data;

    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_id,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_id,
        output resp_data
    );
endinterface

// File: rtl/regfile_read_scheduler.sv
// Round-robin scheduler sharing one register-file read port among NREQ clients:
// stage A holds the granted select, stage R the registered response.
module regfile_read_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    regfile_read_scheduler_if.slave bus,
    output logic [4:0]              rsel,
    input  logic [31:0]             rdata,
    input  logic                    wr_en,
    input  logic [4:0]              wr_addr,
    input  logic [31:0]             wr_data
);
    logic            a_valid_r;
    logic [IDW-1:0]  a_id_r;
    logic [4:0]      rsel_r;
    logic [IDW-1:0]  ptr_r;
    logic            resp_valid_r;
    logic [IDW-1:0]  resp_id_r;
    logic [31:0]     resp_data_r;

    logic            r_accept_s;
    logic            a_adv_s;
    logic            a_accept_s;
    logic            grant_found_s;
    logic            grant_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [IDW-1:0]  ptr_next_s;
    logic [IDW:0]    sum_s;
    logic [IDW:0]    cand_s;
    logic [NREQ-1:0] req_ready_s;
    logic [4:0]      grant_addr_s;
    logic [31:0]     capture_s;

    // R0 is hardwired zero; otherwise a same-cycle write to the selected index wins.
    function automatic logic [31:0] read_value(
        input logic [4:0]  sel,
        input logic [31:0] port_data,
        input logic        we,
        input logic [4:0]  waddr,
        input logic [31:0] wdata
    );
        logic [31:0] val;
        if (sel == 5'd0) begin
            val = 32'd0;
        end else if (we && (waddr == sel)) begin
            val = wdata;
        end else begin
            val = port_data;
        end
        return val;
    endfunction

    // Pipeline advance conditions.
    always_comb begin
        r_accept_s = !resp_valid_r || bus.resp_ready;
        a_adv_s    = a_valid_r && r_accept_s;
        a_accept_s = !a_valid_r || a_adv_s;
    end

    // Round-robin search from ptr upward with wrap-around.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        sum_s         = '0;
        cand_s        = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s  = {1'b0, ptr_r} + (IDW+1)'(k);
            cand_s = (sum_s >= (IDW+1)'(NREQ)) ? (sum_s - (IDW+1)'(NREQ)) : sum_s;
            if (!grant_found_s && bus.req_valid[cand_s[IDW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[IDW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot grant, next pointer and selected address.
    always_comb begin
        grant_s      = grant_found_s && a_accept_s;
        req_ready_s  = '0;
        if (grant_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
        ptr_next_s   = (grant_idx_s == IDW'(NREQ - 1)) ? '0 : (grant_idx_s + IDW'(1));
        grant_addr_s = bus.req_addr[int'(grant_idx_s) * 5 +: 5];
        capture_s    = read_value(rsel_r, rdata, wr_en, wr_addr, wr_data);
    end

    // Stage A (grant capture) and stage R (response) registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_valid_r    <= 1'b0;
            a_id_r       <= '0;
            rsel_r       <= 5'd0;
            ptr_r        <= '0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= '0;
            resp_data_r  <= 32'd0;
        end else begin
            if (grant_s) begin
                rsel_r    <= grant_addr_s;
                a_id_r    <= grant_idx_s;
                a_valid_r <= 1'b1;
                ptr_r     <= ptr_next_s;
            end else if (a_adv_s) begin
                a_valid_r <= 1'b0;
            end
            // Capture happens only when stage A moves, so stalled reads see later writes.
            if (a_adv_s) begin
                resp_valid_r <= 1'b1;
                resp_id_r    <= a_id_r;
                resp_data_r  <= capture_s;
            end else if (resp_valid_r && bus.resp_ready) begin
                resp_valid_r <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_id    = resp_id_r;
    assign bus.resp_data  = resp_data_r;
    assign rsel           = rsel_r;
endmodule

// File: doc/regfile_read_scheduler.md
Name: regfile_read_scheduler

Overview:
- Shares the single 32x32 register-file read port (5-bit select into the 32:1 read mux, 32-bit data back) among NREQ requesters.
- Round-robin arbitration with a valid/ready handshake, a two-stage read pipeline and a registered response with backpressure.
- Provides write-port bypass and a hardwired-zero R0.
- Sits between the pipeline's operand-fetch clients (decode, debug, etc.) and the register file.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester id width, equal to clog2(NREQ)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester read request
req_addr  in  NREQ*5  flattened register indices; requester i uses bits [5i+4:5i]
req_ready  out  NREQ  one-hot grant; request i is accepted in the cycle req_valid[i] and req_ready[i] are both high
rsel  out  5  read select driven to the register-file read mux
rdata  in  32  combinational data returned by the read mux for rsel
wr_en  in  1  register-file write enable, same cycle as the write
wr_addr  in  5  register-file write index
wr_data  in  32  register-file write data
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts the response
resp_id  out  IDW  index of the requester being answered
resp_data  out  32  read result

Behaviour:
- Reset: while reset_n is low at a clock edge, the following are cleared to 0: resp_valid, resp_id, resp_data, rsel, stage-A valid, stage-A id, and the round-robin pointer. req_ready is 0 whenever stage A cannot accept or no request is present.
- Stage A register: a_valid, a_id, and rsel, which is itself the stage-A address register.
- Stage R register: resp_valid, resp_id, resp_data.
- Advance rules:
  - r_accept = !resp_valid | resp_ready
  - a_adv = a_valid & r_accept
  - a_accept = !a_valid | a_adv
- Arbitration (combinational):
  - When a_accept, grant the first i with req_valid[i] high, searching from ptr upward with wrap-around.
  - req_ready = one-hot of that grant, else 0.
  - req_ready never depends on resp_valid except through a_accept.
- On a grant to i at the clock edge:
  - rsel <= req_addr[i]
  - a_id <= i
  - a_valid <= 1
  - ptr <= (i+1) mod NREQ
- With no grant: ptr is unchanged, and a_valid <= 0 if a_adv.
- Stage R capture on a_adv:
  - resp_valid <= 1 and resp_id <= a_id.
  - resp_data <= 0 if rsel==0.
  - Else resp_data <= wr_data if wr_en and wr_addr==rsel (bypass of the write in the same cycle).
  - Else resp_data <= rdata.
- If resp_valid and resp_ready without a_adv: resp_valid <= 0.
- Latency: a request accepted in cycle T presents resp_valid in cycle T+2. Throughput is one read per cycle while resp_ready stays high.
- Backpressure: while resp_valid & !resp_ready, the following hold stable: resp_valid, resp_id, resp_data.
  - If stage A is also full, it holds and req_ready is all 0.
  - While stage A holds, rsel stays driven and the read is re-evaluated every cycle. The value captured is the one present in the cycle stage A advances, so writes during the stall are observed.
- Bypass applies only in the capture cycle. Writes to R0 are never bypassed; R0 always reads 0.
- Requesters must hold req_valid and req_addr until accepted. The scheduler does not check this.
- Starvation: with all requesters continuously valid, each one is granted exactly once in every NREQ consecutive grants.
- Reset asserted mid-operation discards in-flight stage-A and stage-R contents. No response is produced for them.

Test Plan:
- Reset then single request: req_valid=0001, addr0=7, rdata=0xDEADBEEF when rsel=7 -> req_ready=0001 in cycle T; rsel=7 in T+1; resp_valid=1, resp_id=0, resp_data=0xDEADBEEF in T+2.
- All four requesters valid continuously, resp_ready=1 -> grants in order 0,1,2,3,0,...; resp_id follows the same order; one response per cycle.
- Bypass: stage A holds rsel=5 while wr_en=1, wr_addr=5, wr_data=0x12345678 and rdata=old value -> resp_data=0x12345678. Repeat with rsel=0 and wr_addr=0 -> resp_data=0.
- Backpressure: resp_ready=0 for 3 cycles with requests pending -> resp_* stable, at most one more grant then req_ready=0000; on resp_ready=1, the next response arrives the following cycle with no loss or duplication.
- Stall re-read: stage A stalled on rsel=9 while R9 is written from 0x1 to 0x2 via wr_en (rdata updates accordingly) -> delivered resp_data=0x2.
- Reset mid-flight: two requests in the pipeline, reset_n=0 for one edge -> resp_valid=0, rsel=0, ptr=0; the first grant after reset goes to requester 0 when all are valid.
